// File: rtl/step_pkg.sv
// Coil phase codes, decoder state encoding and the pattern-to-phase lookup
// shared by the drive and receive sides of the stepper path.
package step_pkg;

    localparam logic [3:0] PH_P0  = 4'b1100;
    localparam logic [3:0] PH_P1  = 4'b0110;
    localparam logic [3:0] PH_P2  = 4'b0011;
    localparam logic [3:0] PH_P3  = 4'b1001;
    localparam logic [3:0] PH_OFF = 4'b0000;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOCKED = 2'b01;
    localparam logic [1:0] ST_FAULT  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } phase_dec_t;

    // Maps a coil pattern to its phase index; valid=0 for OFF and illegal codes.
    function automatic phase_dec_t phase_index(input logic [3:0] pat);
        phase_dec_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (pat)
            PH_P0:   r.idx = 2'd0;
            PH_P1:   r.idx = 2'd1;
            PH_P2:   r.idx = 2'd2;
            PH_P3:   r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync2_bus.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync2_bus #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_phase_decoder.sv
// Recovers step events, direction, shaft position and revolution digit from
// the four stepper coil lines; flags illegal patterns and skipped phases.
module step_phase_decoder
    import step_pkg::*;
#(
    parameter int unsigned STEPS_PER_REV = 24,
    parameter int unsigned SENSE_W       = 4,
    parameter int unsigned POS_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_in,
    input  logic             clr_err,
    output logic             step_pulse,
    output logic             dir,
    output logic [POS_W-1:0] pos_cnt,
    output logic             motor_sense,
    output logic [3:0]       rev_digit,
    output logic             err_seq,
    output logic             locked
);

    localparam int unsigned SENSE_CW = $clog2(SENSE_W + 1);

    logic [3:0]          ph_sync;
    phase_dec_t          dec;
    logic                is_off;
    logic [1:0]          ph_delta;
    logic [1:0]          state, state_nxt;
    logic [1:0]          last_ph, last_nxt;
    logic                fwd, rev, seq_err;
    logic                pos_at_top, pos_at_zero, pos_at_one;
    logic                index_ev;
    logic [SENSE_CW-1:0] sense_cnt;

    sync2_bus #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (phase_in),
        .q   (ph_sync)
    );

    assign dec      = phase_index(ph_sync);
    assign is_off   = (ph_sync == PH_OFF);
    assign ph_delta = dec.idx - last_ph;

    always_comb begin
        state_nxt = state;
        last_nxt  = last_ph;
        fwd       = 1'b0;
        rev       = 1'b0;
        seq_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec.valid) begin
                    state_nxt = ST_LOCKED;
                    last_nxt  = dec.idx;
                end else if (!is_off) begin
                    state_nxt = ST_FAULT;
                    seq_err   = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (dec.valid) begin
                    last_nxt = dec.idx;
                    // Modulo-4 phase distance: +1 forward, -1 (3) reverse, 2 is a skip
                    case (ph_delta)
                        2'd1:    fwd = 1'b1;
                        2'd3:    rev = 1'b1;
                        2'd2: begin
                            state_nxt = ST_FAULT;
                            seq_err   = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (is_off) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_FAULT;
                    seq_err   = 1'b1;
                end
            end
            ST_FAULT: begin
                if (is_off) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            last_ph <= 2'd0;
        end else begin
            state   <= state_nxt;
            last_ph <= last_nxt;
        end
    end

    assign pos_at_top  = (pos_cnt == POS_W'(STEPS_PER_REV - 1));
    assign pos_at_zero = (pos_cnt == '0);
    assign pos_at_one  = (pos_cnt == POS_W'(1));
    // Index fires on arrival at 0 only: forward wrap or reverse 1 -> 0
    assign index_ev    = (fwd && pos_at_top) || (rev && pos_at_one);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_pulse <= 1'b0;
            dir        <= 1'b0;
            pos_cnt    <= '0;
            rev_digit  <= 4'd0;
        end else begin
            step_pulse <= fwd | rev;
            if (fwd) begin
                dir <= 1'b1;
                if (pos_at_top) begin
                    pos_cnt   <= '0;
                    rev_digit <= (rev_digit == 4'd9) ? 4'd0 : rev_digit + 4'd1;
                end else begin
                    pos_cnt <= pos_cnt + POS_W'(1);
                end
            end else if (rev) begin
                dir <= 1'b0;
                if (pos_at_zero) begin
                    pos_cnt   <= POS_W'(STEPS_PER_REV - 1);
                    rev_digit <= (rev_digit == 4'd0) ? 4'd9 : rev_digit - 4'd1;
                end else begin
                    pos_cnt <= pos_cnt - POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sense_cnt <= '0;
        end else if (index_ev) begin
            sense_cnt <= SENSE_CW'(SENSE_W);
        end else if (sense_cnt != '0) begin
            sense_cnt <= sense_cnt - SENSE_CW'(1);
        end
    end

    assign motor_sense = (sense_cnt != '0);

    // A new error wins over a coincident clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_seq <= 1'b0;
        end else if (seq_err) begin
            err_seq <= 1'b1;
        end else if (clr_err) begin
            err_seq <= 1'b0;
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule
